// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: definitions shared by the PS/2 receiver and the downstream
// break-code/data capture stage.
//   state_t        receiver FSM encoding (IDLE/DPS/LOAD)
//   PS2_FRAME_BITS start + 8 data + parity + stop
//   PS2_BREAK_CODE key-release prefix byte
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DPS  = 2'b01,
        LOAD = 2'b10
    } state_t;

    localparam int          PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: byte interface between the PS/2 receiver and its consumer.
//   rx_en         consumer -> receiver, 1 = accept new frames
//   dout          last cleanly received byte
//   rx_done_tick  one-cycle strobe, dout is new
//   parity_err    one-cycle strobe, frame dropped for bad parity
//   frame_err     one-cycle strobe, frame dropped for stop=0 or timeout
interface ps2_rx_if;
    import ps2_rx_pkg::*;

    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    modport master (
        input  rx_en,
        output dout,
        output rx_done_tick,
        output parity_err,
        output frame_err
    );

    modport slave (
        output rx_en,
        input  dout,
        input  rx_done_tick,
        input  parity_err,
        input  frame_err
    );

endinterface

// File: rtl/ps2_rx_clk_filter.sv
// ps2_clk_filter: PS/2 pin front end.
//   clk, reset   system clock, asynchronous active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   fall_tick    one-cycle pulse on a de-glitched ps2_clk falling edge
//   data_sync    synchronized ps2_data, valid to sample with fall_tick
// The filtered level only changes once FILTER_LEN consecutive synchronized
// samples agree, so shorter pulses on ps2_clk never produce a fall_tick.
module ps2_clk_filter
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_tick,
    output logic data_sync
);

    logic                  clk_p0, clk_p1;
    logic                  dat_p0, dat_p1;
    logic [FILTER_LEN-2:0] hist_p2;
    logic [FILTER_LEN-1:0] win;
    logic                  filt_lvl_p2;
    logic                  filt_nxt;

    // The newest synchronized sample is part of the window, so the level
    // and the edge register update on the same clock.
    assign win = {hist_p2, clk_p1};

    always_comb begin
        filt_nxt = filt_lvl_p2;
        if (&win)
            filt_nxt = 1'b1;
        else if (~|win)
            filt_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_p0      <= 1'b1;
            clk_p1      <= 1'b1;
            dat_p0      <= 1'b1;
            dat_p1      <= 1'b1;
            hist_p2     <= '1;
            filt_lvl_p2 <= 1'b1;
            fall_tick   <= 1'b0;
        end else begin
            // synchronizer stages
            clk_p0      <= ps2_clk;
            clk_p1      <= clk_p0;
            dat_p0      <= ps2_data;
            dat_p1      <= dat_p0;
            // filter window, filtered level and edge register
            hist_p2     <= win[FILTER_LEN-2:0];
            filt_lvl_p2 <= filt_nxt;
            fall_tick   <= filt_lvl_p2 & ~filt_nxt;
        end
    end

    assign data_sync = dat_p1;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
//   clk, reset   system clock, asynchronous active-high reset
//   ps2_clk      raw PS/2 clock pin
//   ps2_data     raw PS/2 data pin
//   bus          ps2_rx_if.master: rx_en in; dout, rx_done_tick,
//                parity_err, frame_err out
// Deserializes start, 8 data bits LSB first, odd parity, stop. Only frames
// with stop=1 and correct parity update dout; anything else raises exactly
// one error strobe. A frame that stalls for TIMEOUT_CYC cycles is aborted.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.master bus
);

    localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CYC - 1);
    // bits still to shift once the start bit is seen: 8 data + parity + stop
    localparam logic [3:0]     BITS_AFTER_START = 4'(PS2_FRAME_BITS - 2);

    logic          fall_tick;
    logic          data_sync;

    state_t        state, state_n;
    logic [9:0]    b, b_n;
    logic [3:0]    cnt, cnt_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [7:0]    dout_r, dout_n;
    logic          done_r, done_n;
    logic          perr_r, perr_n;
    logic          ferr_r, ferr_n;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .fall_tick (fall_tick),
        .data_sync (data_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            b      <= '0;
            cnt    <= '0;
            tmr    <= '0;
            dout_r <= 8'h00;
            done_r <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            state  <= state_n;
            b      <= b_n;
            cnt    <= cnt_n;
            tmr    <= tmr_n;
            dout_r <= dout_n;
            done_r <= done_n;
            perr_r <= perr_n;
            ferr_r <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        b_n     = b;
        cnt_n   = cnt;
        tmr_n   = tmr;
        dout_n  = dout_r;
        done_n  = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;

        case (state)
            IDLE: begin
                tmr_n = '0;
                // rx_en gates only new start bits, never a frame in progress
                if (fall_tick && bus.rx_en && !data_sync) begin
                    state_n = DPS;
                    cnt_n   = BITS_AFTER_START;
                end
            end

            DPS: begin
                if (fall_tick) begin
                    b_n   = {data_sync, b[9:1]};
                    tmr_n = '0;
                    if (cnt == 4'd0)
                        state_n = LOAD;
                    else
                        cnt_n = cnt - 4'd1;
                end else if (tmr == TMR_LAST) begin
                    // the counter never passes TMR_LAST: it aborts here
                    ferr_n  = 1'b1;
                    tmr_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end

            LOAD: begin
                state_n = IDLE;
                if (!b[9])
                    ferr_n = 1'b1;
                else if (!(^b[8:0]))
                    perr_n = 1'b1;
                else begin
                    dout_n = b[7:0];
                    done_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.dout         = dout_r;
    assign bus.rx_done_tick = done_r;
    assign bus.parity_err   = perr_r;
    assign bus.frame_err    = ferr_r;

endmodule
